// File: rtl/crc_fsk_pkg.sv
// Shared constants and types for the CRC/FSK link.
// Holds frame geometry, idle byte and the feeder FSM state enum.
package crc_fsk_pkg;

   localparam int         FRAME_SYMBOLS     = 16;
   localparam int         SYM_CNT_W         = 4;
   localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'h00;

   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_RUN_IDLE = 2'd1,
      ST_RUN_DATA = 2'd2
   } tx_feed_state_t;

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; head byte is shown combinationally.
// Push is ignored when full, pop is ignored when empty.
module tx_byte_fifo #(
   parameter int DEPTH = 8,
   parameter int PW    = $clog2(DEPTH) + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [7:0]    i_wdata,
   output logic [7:0]    o_rdata,
   output logic          o_full,
   output logic          o_empty,
   output logic [PW-1:0] o_level
);

   logic [7:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                      (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
   assign o_empty   = (r_wptr == r_rptr);
   assign o_level   = r_wptr - r_rptr;
   assign o_rdata   = r_mem[r_rptr[PW-2:0]];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Pointer advance; reset discards all contents.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      end
   end

   // Storage write; contents need no reset.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wptr[PW-2:0]] <= i_wdata;
   end

endmodule

// File: rtl/tx_frame_feeder.sv
// One byte per 16-symbol frame to the CRC encoder, fed from a FIFO.
// Optional frame statistics with TX_FEEDER_STATS_EN.
module tx_frame_feeder
   import crc_fsk_pkg::*;
#(
   parameter int         DEPTH     = 8,
   parameter logic [7:0] IDLE_BYTE = DEFAULT_IDLE_BYTE
) (
   input  logic                   sys_clk,
   input  logic                   reset,
   input  logic [SYM_CNT_W-1:0]   sign_cnt,
   input  logic                   tx_en,
   input  logic                   wr_valid,
   input  logic [7:0]             wr_data,
   output logic                   wr_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_data_valid,
   output logic                   frame_start,
   output logic [$clog2(DEPTH):0] fifo_level
`ifdef TX_FEEDER_STATS_EN
   ,
   output logic [15:0]            data_frames,
   output logic [15:0]            idle_frames
`endif
);

   localparam int LW = $clog2(DEPTH) + 1;

   tx_feed_state_t       r_state;
   tx_feed_state_t       w_state_nxt;
   logic [SYM_CNT_W-1:0] r_sign_cnt_q;
   logic [7:0]           r_tx_data;
   logic                 r_tx_valid;
   logic                 r_frame_start;
   logic [7:0]           w_data_nxt;
   logic                 w_valid_nxt;
   logic                 w_boundary;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic [7:0]           w_head;
   logic [LW-1:0]        w_level;

   assign w_boundary    = (sign_cnt == '0) && (r_sign_cnt_q != '0);
   assign w_push        = wr_valid && !w_full;
   assign wr_ready      = !w_full;
   assign tx_data       = r_tx_data;
   assign tx_data_valid = r_tx_valid;
   assign frame_start   = r_frame_start;
   assign fifo_level    = w_level;

   tx_byte_fifo #(
      .DEPTH (DEPTH),
      .PW    (LW)
   ) u_fifo (
      .i_clk   (sys_clk),
      .i_rst   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (wr_data),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   // Frame decision at each boundary: off, idle or pop a byte.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_data_nxt  = r_tx_data;
      w_valid_nxt = r_tx_valid;
      if (w_boundary) begin
         if (!tx_en) begin
            w_state_nxt = ST_OFF;
            w_data_nxt  = IDLE_BYTE;
            w_valid_nxt = 1'b0;
         end else if (!w_empty) begin
            w_state_nxt = ST_RUN_DATA;
            w_pop       = 1'b1;
            w_data_nxt  = w_head;
            w_valid_nxt = 1'b1;
         end else begin
            w_state_nxt = ST_RUN_IDLE;
            w_data_nxt  = IDLE_BYTE;
            w_valid_nxt = 1'b0;
         end
      end
   end

   // State, held frame outputs and symbol counter history.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_OFF;
         r_sign_cnt_q  <= '0;
         r_tx_data     <= IDLE_BYTE;
         r_tx_valid    <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_sign_cnt_q  <= sign_cnt;
         r_tx_data     <= w_data_nxt;
         r_tx_valid    <= w_valid_nxt;
         r_frame_start <= w_boundary;
      end
   end

`ifdef TX_FEEDER_STATS_EN
   logic [15:0] r_data_frames;
   logic [15:0] r_idle_frames;

   assign data_frames = r_data_frames;
   assign idle_frames = r_idle_frames;

   // Saturating per-boundary frame counters.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         r_data_frames <= '0;
         r_idle_frames <= '0;
      end else if (w_boundary) begin
         if (w_state_nxt == ST_RUN_DATA) begin
            if (r_data_frames != 16'hFFFF)
               r_data_frames <= r_data_frames + 16'd1;
         end else begin
            if (r_idle_frames != 16'hFFFF)
               r_idle_frames <= r_idle_frames + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_tx_frame_feeder.sv
// Randomized and directed bench for tx_frame_feeder against a queue model.
// Stats checks compile in when TX_FEEDER_STATS_EN is defined.
module tb_tx_frame_feeder;

   localparam int DEPTH = 8;

   logic       sys_clk;
   logic       reset;
   logic [3:0] sign_cnt;
   logic       tx_en;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       frame_start;
   logic [3:0] fifo_level;
`ifdef TX_FEEDER_STATS_EN
   logic [15:0] data_frames;
   logic [15:0] idle_frames;
`endif

   tx_frame_feeder #(
      .DEPTH     (DEPTH),
      .IDLE_BYTE (8'h00)
   ) dut (
      .sys_clk       (sys_clk),
      .reset         (reset),
      .sign_cnt      (sign_cnt),
      .tx_en         (tx_en),
      .wr_valid      (wr_valid),
      .wr_data       (wr_data),
      .wr_ready      (wr_ready),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .frame_start   (frame_start),
      .fifo_level    (fifo_level)
`ifdef TX_FEEDER_STATS_EN
      ,
      .data_frames   (data_frames),
      .idle_frames   (idle_frames)
`endif
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: what the link should be carrying.
   logic [7:0]  mq[$];
   logic [7:0]  src[$];
   logic [3:0]  m_prev;
   logic [7:0]  m_data;
   bit          m_valid;
   bit          m_fs;
   int unsigned m_dcnt;
   int unsigned m_icnt;
   bit          push_ok;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   function automatic void count_frame(input bit is_data);
      if (is_data) begin
         if (m_dcnt < 65535) m_dcnt++;
      end else begin
         if (m_icnt < 65535) m_icnt++;
      end
   endfunction

   // Drive one cycle, advance the model, then compare after the edge.
   task automatic tick(input logic [3:0] sc);
      bit bnd;
      bit acc;
      int lvl;
      sign_cnt = sc;
      wr_valid = push_ok && (src.size() > 0);
      wr_data  = wr_valid ? src[0] : 8'h00;
      lvl = mq.size();
      bnd = (sc == 4'd0) && (m_prev != 4'd0);
      acc = wr_valid && (lvl < DEPTH);
      m_fs = bnd;
      if (bnd) begin
         if (!tx_en) begin
            m_data  = 8'h00;
            m_valid = 1'b0;
            count_frame(1'b0);
         end else if (lvl > 0) begin
            m_data  = mq.pop_front();
            m_valid = 1'b1;
            count_frame(1'b1);
         end else begin
            m_data  = 8'h00;
            m_valid = 1'b0;
            count_frame(1'b0);
         end
      end
      if (acc) mq.push_back(src.pop_front());
      m_prev = sc;
      @(posedge sys_clk);
      #1;
      chk("tx_data", tx_data, m_data);
      chk("tx_data_valid", tx_data_valid, m_valid);
      chk("frame_start", frame_start, m_fs);
      chk("fifo_level", fifo_level, mq.size());
      chk("wr_ready", wr_ready, mq.size() < DEPTH);
`ifdef TX_FEEDER_STATS_EN
      chk("data_frames", data_frames, m_dcnt);
      chk("idle_frames", idle_frames, m_icnt);
`endif
   endtask

   task automatic frame();
      for (int s = 0; s < 16; s++) tick(4'(s));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge sys_clk);
      #1;
      reset = 1'b0;
      mq.delete();
      src.delete();
      m_prev  = 4'd0;
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_fs    = 1'b0;
      m_dcnt  = 0;
      m_icnt  = 0;
      wr_valid = 1'b0;
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_valid", tx_data_valid, 1'b0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ready", wr_ready, 1'b1);
      chk("rst_fs", frame_start, 1'b0);
   endtask

   initial begin
      logic [7:0] b0;
      int sc;
      reset    = 1'b1;
      sign_cnt = 4'd0;
      tx_en    = 1'b0;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      push_ok  = 1'b0;
      @(posedge sys_clk);
      #1;
      do_reset();

      // Reset with bytes queued and transmit enabled.
      tx_en = 1'b1;
      push_ok = 1'b1;
      src.push_back(8'h11);
      src.push_back(8'h22);
      src.push_back(8'h33);
      repeat (3) tick(4'd5);
      chk("queued3", fifo_level, 3);
      do_reset();

      // Ordered delivery.
      tx_en = 1'b1;
      src.push_back(8'hA5);
      src.push_back(8'h3C);
      repeat (2) tick(4'd3);
      tick(4'd0);
      chk("ord0", tx_data, 8'hA5);
      chk("ord0v", tx_data_valid, 1'b1);
      for (int s = 1; s < 16; s++) tick(4'(s));
      tick(4'd0);
      chk("ord1", tx_data, 8'h3C);
      for (int s = 1; s < 16; s++) tick(4'(s));
      tick(4'd0);
      chk("ord2", tx_data, 8'h00);
      chk("ord2v", tx_data_valid, 1'b0);
      for (int s = 1; s < 16; s++) tick(4'(s));

      // Full FIFO with a ninth byte held by the producer.
      for (int i = 0; i < 9; i++) src.push_back(8'(8'h40 + i));
      repeat (10) tick(4'd5);
      chk("full_lvl", fifo_level, 8);
      chk("full_rdy", wr_ready, 1'b0);
      chk("full_held", wr_valid, 1'b1);
      tick(4'd0);
      chk("full_pop", tx_data, 8'h40);
      chk("full_lvl7", fifo_level, 7);
      tick(4'd1);
      chk("ninth_acc", fifo_level, 8);
      for (int s = 2; s < 16; s++) tick(4'(s));
      repeat (9) frame();
      chk("drained", fifo_level, 0);

      // Simultaneous push and pop at level 4.
      for (int i = 0; i < 12; i++) src.push_back(8'($urandom));
      repeat (4) tick(4'd1);
      chk("lvl4", fifo_level, 4);
      push_ok = 1'b0;
      for (int f = 0; f < 8; f++) begin
         for (int s = 0; s < 16; s++) begin
            push_ok = (s == 0);
            tick(4'(s));
            if (s == 0) chk("pp_lvl4", fifo_level, 4);
         end
      end
      push_ok = 1'b0;
      repeat (5) frame();

      // Transmit enable dropped mid-frame.
      push_ok = 1'b1;
      src.push_back(8'h5A);
      src.push_back(8'hC3);
      tick(4'd1);
      tick(4'd2);
      push_ok = 1'b0;
      for (int s = 0; s < 7; s++) tick(4'(s));
      b0 = tx_data;
      chk("en_first", b0, 8'h5A);
      tx_en = 1'b0;
      for (int s = 7; s < 16; s++) tick(4'(s));
      chk("en_hold", tx_data, 8'h5A);
      tick(4'd0);
      chk("en_off", tx_data, 8'h00);
      chk("en_offv", tx_data_valid, 1'b0);
      chk("en_keep", fifo_level, 1);
      for (int s = 1; s < 16; s++) tick(4'(s));

      // Randomized traffic with irregular symbol counts.
      sc = 1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) < 3) tx_en = ~tx_en;
         push_ok = ($urandom_range(0, 3) != 0);
         if (src.size() < 4 && $urandom_range(0, 7) == 0)
            src.push_back(8'($urandom));
         if ($urandom_range(0, 49) == 0) sc = $urandom_range(0, 15);
         else if ($urandom_range(0, 19) != 0) sc = (sc + 1) % 16;
         tick(4'(sc));
         if (c == 1500) do_reset();
      end

`ifdef TX_FEEDER_STATS_EN
      do_reset();
      tx_en = 1'b1;
      push_ok = 1'b1;
      for (int i = 0; i < 5; i++) src.push_back(8'(i + 1));
      repeat (5) tick(4'd1);
      push_ok = 1'b0;
      repeat (8) frame();
      chk("st_data", data_frames, 16'd5);
      chk("st_idle", idle_frames, 16'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tx_frame_feeder.md
# tx_frame_feeder

Transmit-side byte scheduler that sits directly upstream of the CRC-8 encoder in the CRC/FSK link. It accepts bytes from a producer over a valid/ready handshake and buffers them in a small FIFO. It presents exactly one byte per 16-symbol frame on `tx_data`, changing it only at frame boundaries taken from the symbol counter. When no byte is available, it sends an idle byte and flags the frame as not carrying data.

## Interface
- `DEPTH`, 8: FIFO depth in bytes; power of two, 2..64.
- `IDLE_BYTE`, 8'h00: byte driven during idle or off frames.
- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sign_cnt`  in  4  symbol index within the frame (0..15), from the clock/symbol generator, synchronous to `sys_clk`.
- `tx_en`  in  1  transmit enable.
- `wr_valid`  in  1  producer has a byte.
- `wr_data`  in  8  producer byte.
- `wr_ready`  out  1  FIFO can accept a byte.
- `tx_data`  out  8  byte to the CRC encoder (`data_in`).
- `tx_data_valid`  out  1  current frame carries a FIFO byte.
- `frame_start`  out  1  one-cycle pulse when `tx_data` is updated.
- `fifo_level`  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- **Boundary detection**
  - `sign_cnt_q` registers `sign_cnt`.
  - `boundary = (sign_cnt == 0) && (sign_cnt_q != 0)`.
  - A counter held at 0 gives a single boundary.
- **Push**
  - A push occurs when `wr_valid && wr_ready`.
  - `wr_ready = !full`, computed from the registered level.
  - A push is refused when the FIFO is full, even on a pop cycle.
- **FSM states:** OFF, RUN_IDLE, RUN_DATA. All transitions occur only on `boundary`.
  - From any state, with `tx_en` = 0: go to OFF. Drive `tx_data = IDLE_BYTE`, `tx_data_valid = 0`, no pop, FIFO retained.
  - With `tx_en` = 1 and the FIFO non-empty (registered level): pop the head into `tx_data`, set `tx_data_valid = 1`, go to RUN_DATA.
  - With `tx_en` = 1 and the FIFO empty: drive `IDLE_BYTE`, set `tx_data_valid = 0`, go to RUN_IDLE.
- **Frame hold:** `tx_data` and `tx_data_valid` are held constant between boundaries.
- **`tx_en` mid-frame:** deasserting or asserting `tx_en` mid-frame has no effect until the next boundary.
- **Pointers:** read and write pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - Full means the MSBs differ and the low bits are equal.
  - `fifo_level = wptr - rptr` (modular).
- **Push and pop in the same cycle:** both take effect; `fifo_level` is unchanged.
- **Push into an empty FIFO on a boundary cycle:** that frame is idle. The byte goes out at the next boundary.

## Timing
- **Boundary latency:** `tx_data`, `tx_data_valid` and `frame_start` change on the `sys_clk` edge that samples `boundary`. This is one `sys_clk` after `sign_cnt` becomes 0.
  - Downstream samples per symbol at `sign_clk` rate, so symbol 0 is stable well before sampling.
- **`frame_start`:** high for exactly that one cycle.
- **Handshake latency:** `wr_ready` reflects a pop one cycle after the boundary. A pushed byte is visible in `fifo_level` the next cycle.
- **Reset values:**
  - `state` = OFF, `tx_data = IDLE_BYTE`, `tx_data_valid = 0`, `frame_start = 0`.
  - `fifo_level = 0`, `wr_ready = 1`, pointers 0, `sign_cnt_q = 0`.
  - Stats are 0.
- **Reset mid-frame:** the FIFO is discarded and no byte is emitted. After release, the first boundary occurs when `sign_cnt` next returns to 0 from a non-zero value.

## Configuration
- **`TX_FEEDER_STATS_EN` defined:** adds two outputs.
  - `data_frames` (16 bits) increments on each boundary entering RUN_DATA.
  - `idle_frames` (16 bits) increments on each boundary entering RUN_IDLE or OFF.
  - Both saturate at 16'hFFFF and are cleared by `reset`.
- **Undefined:** the ports and counters do not exist; all other behaviour is identical.

## Structure
- **Shared package `crc_fsk_pkg`:**
  - `FRAME_SYMBOLS = 16`, `SYM_CNT_W = 4`, `DEFAULT_IDLE_BYTE = 8'h00`.
  - The FSM state enum `tx_feed_state_t`.
- **Sub-module `tx_byte_fifo`:** synchronous FIFO with push, pop, full, empty and level. The FSM and boundary logic stay in `tx_frame_feeder`.

## Test plan
- **Reset:** `reset` pulsed with `tx_en` = 1 and 3 bytes queued → `tx_data` = 8'h00, `tx_data_valid` = 0, `fifo_level` = 0, `wr_ready` = 1.
- **Ordered delivery:** push 8'hA5, 8'h3C; `tx_en` = 1 → the next two boundaries give 8'hA5 then 8'h3C with `tx_data_valid` = 1. The third boundary gives 8'h00 with `tx_data_valid` = 0.
- **Full FIFO:** push 9 bytes back-to-back (`DEPTH` = 8) → `wr_ready` = 0 after 8, the 9th is held by the producer, `fifo_level` = 8. After one boundary: `fifo_level` = 7 and the 9th is accepted.
- **Push and pop together:** simultaneous push and boundary pop at level 4 → level stays 4 and byte order is preserved across 8 frames, including pointer wrap.
- **`tx_en` drop:** `tx_en` dropped at `sign_cnt` = 7 → `tx_data` is unchanged until `sign_cnt` returns to 0, then 8'h00 with no pop. The FIFO level is retained.
- **Stats (with `TX_FEEDER_STATS_EN`):** 5 data frames then 3 empty frames → `data_frames` = 5, `idle_frames` = 3.
